// File: rtl/uart_ctl_pkg.sv
// Shared definitions for the memory-mapped UART controller: register offsets
// (mem_addr[3:2]), STATUS/CTRL bit positions and the TX drain FSM state type.
package uart_ctl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_FULL      = 3;
  localparam int ST_TX_BUSY      = 4;
  localparam int ST_RX_OVERRUN   = 5;
  localparam int ST_FRAME_ERR    = 6;
  localparam int ST_RX_COUNT_LSB = 16;

  localparam int CTRL_RX_IE    = 0;
  localparam int CTRL_TX_IE    = 1;
  localparam int CTRL_TX_FLUSH = 2;
  localparam int CTRL_RX_FLUSH = 3;
  localparam int CTRL_CLR_ERR  = 4;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_START   = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush.
// Ports: clk, reset (async, active-high); push/wdata write side; pop/rdata
// read side (rdata shows the head entry combinationally while !empty);
// flush empties the FIFO in one cycle and wins over a simultaneous push/pop;
// full/empty/count report occupancy.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);

  // Pointers are DEPTH-sized (power of two) so increments wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_controller.sv
// Memory-mapped UART controller with TX/RX FIFOs.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   mem_valid/mem_ready   CPU request / one-cycle completion pulse
//   mem_addr[3:2]         register select (DATA, STATUS, CTRL, reserved)
//   mem_wdata/mem_wstrb   write data / nonzero strobe means write
//   mem_rdata             read data, valid with mem_ready
//   irq                   registered level interrupt
//   uart_transmit/uart_tx_byte       start pulse and byte to the uart core
//   uart_received/uart_rx_byte       received byte strobe from the core
//   uart_is_transmitting             core busy
//   uart_recv_error                  framing error pulse
module uart_fifo_controller
  import uart_ctl_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        irq,
  output logic        uart_transmit,
  output logic [7:0]  uart_tx_byte,
  input  logic        uart_received,
  input  logic [7:0]  uart_rx_byte,
  input  logic        uart_is_transmitting,
  input  logic        uart_recv_error
);

  localparam int TX_CW = $clog2(TX_DEPTH+1);
  localparam int RX_CW = $clog2(RX_DEPTH+1);

  logic [1:0]       reg_sel;
  logic             is_write;
  logic             stall;
  logic             accept;
  logic             wr_acc;
  logic             rd_acc;
  logic             ctrl_wr;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_flush;
  logic             rx_pop;
  logic             rx_flush;
  logic             clr_err;
  logic             rx_overrun_set;

  logic [7:0]       tx_rdata;
  logic             tx_full;
  logic             tx_empty;
  logic [TX_CW-1:0] tx_count;
  logic [7:0]       rx_rdata;
  logic             rx_full;
  logic             rx_empty;
  logic [RX_CW-1:0] rx_count;

  logic             rx_ie;
  logic             tx_ie;
  logic             rx_overrun;
  logic             frame_err;
  tx_state_t        tx_state;

  logic [31:0]      status_word;
  logic [31:0]      read_data;
  logic             unused_bits;

  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8], tx_count};

  assign reg_sel  = mem_addr[3:2];
  assign is_write = |mem_wstrb;
  // Only a DATA write into a full TX FIFO waits; everything else is accepted.
  assign stall    = is_write && (reg_sel == REG_DATA) && tx_full;
  assign accept   = mem_valid && !mem_ready && !stall;
  assign wr_acc   = accept && is_write;
  assign rd_acc   = accept && !is_write;
  assign ctrl_wr  = wr_acc && (reg_sel == REG_CTRL);
  assign tx_push  = wr_acc && (reg_sel == REG_DATA);
  assign tx_flush = ctrl_wr && mem_wdata[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr && mem_wdata[CTRL_RX_FLUSH];
  assign clr_err  = ctrl_wr && mem_wdata[CTRL_CLR_ERR];
  assign rx_pop   = rd_acc && (reg_sel == REG_DATA) && !rx_empty;

  // A full RX FIFO still keeps the new byte when a read pops in the same cycle.
  assign rx_overrun_set = uart_received && rx_full && !rx_pop && !rx_flush;

  assign tx_pop = (tx_state == TX_IDLE) && !tx_empty && !uart_is_transmitting && !tx_flush;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .wdata (mem_wdata[7:0]),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (uart_received),
    .pop   (rx_pop),
    .flush (rx_flush),
    .wdata (uart_rx_byte),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    status_word                  = '0;
    status_word[ST_RX_NOT_EMPTY] = !rx_empty;
    status_word[ST_RX_FULL]      = rx_full;
    status_word[ST_TX_EMPTY]     = tx_empty;
    status_word[ST_TX_FULL]      = tx_full;
    status_word[ST_TX_BUSY]      = uart_is_transmitting;
    status_word[ST_RX_OVERRUN]   = rx_overrun;
    status_word[ST_FRAME_ERR]    = frame_err;
    status_word[31:ST_RX_COUNT_LSB] = 16'(rx_count);
  end

  always_comb begin
    read_data = '0;
    case (reg_sel)
      REG_DATA:   read_data = rx_empty ? 32'h0 : {24'h0, rx_rdata};
      REG_STATUS: read_data = status_word;
      REG_CTRL:   read_data = {30'h0, tx_ie, rx_ie};
      default:    read_data = '0;
    endcase
  end

  // Bus response: ready and read data one cycle after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= accept;
      if (accept) mem_rdata <= rd_acc ? read_data : 32'h0;
    end
  end

  // Interrupt enables and sticky error flags; a new error event outranks a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ie      <= 1'b0;
      tx_ie      <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_ie <= mem_wdata[CTRL_RX_IE];
        tx_ie <= mem_wdata[CTRL_TX_IE];
      end
      if (rx_overrun_set)       rx_overrun <= 1'b1;
      else if (clr_err)         rx_overrun <= 1'b0;
      if (uart_recv_error)      frame_err  <= 1'b1;
      else if (clr_err)         frame_err  <= 1'b0;
    end
  end

  // TX drain FSM: pop one byte, pulse the core, wait for its busy high then low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state     <= TX_IDLE;
      uart_tx_byte <= 8'h0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            uart_tx_byte <= tx_rdata;
            tx_state     <= TX_START;
          end
        end
        TX_START:   tx_state <= TX_WAIT_HI;
        TX_WAIT_HI: if (uart_is_transmitting)  tx_state <= TX_WAIT_LO;
        TX_WAIT_LO: if (!uart_is_transmitting) tx_state <= TX_IDLE;
        default:    tx_state <= TX_IDLE;
      endcase
    end
  end

  assign uart_transmit = (tx_state == TX_START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (rx_ie && !rx_empty) || (tx_ie && tx_empty);
  end

endmodule

// File: tb/tb_uart_fifo_controller.sv
module tb_uart_fifo_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        irq;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic        uart_received = 1'b0;
  logic [7:0]  uart_rx_byte = '0;
  logic        uart_is_transmitting;
  logic        uart_recv_error = 1'b0;

  int checks = 0;
  int errors = 0;
  int tx_pulses = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  // Simple uart core model: busy for 4 cycles after each start pulse, or forced busy.
  logic force_busy = 1'b0;
  int   busy_cnt = 0;
  assign uart_is_transmitting = force_busy || (busy_cnt != 0);

  always #5 clk = ~clk;

  uart_fifo_controller #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .mem_valid            (mem_valid),
    .mem_ready            (mem_ready),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_wstrb            (mem_wstrb),
    .mem_rdata            (mem_rdata),
    .irq                  (irq),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_received        (uart_received),
    .uart_rx_byte         (uart_rx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .uart_recv_error      (uart_recv_error)
  );

  always @(posedge clk) begin
    if (uart_transmit)      busy_cnt <= 4;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // TX scoreboard: every start pulse must carry the next expected byte.
  always @(negedge clk) begin
    if (uart_transmit) begin
      logic [7:0] e;
      tx_pulses++;
      checks++;
      if (tx_exp.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected_pulse: got byte %h, required no pulse", uart_tx_byte);
      end else begin
        e = tx_exp.pop_front();
        if (uart_tx_byte !== e) begin
          errors++;
          $display("FAIL tx_byte: got %h, required %h", uart_tx_byte, e);
        end
      end
    end
  end

  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata,
                            output int waited);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    waited = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      waited++;
      if (mem_ready) break;
    end
    rdata = mem_rdata;
    if (!mem_ready) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout: addr %h got no mem_ready, required ready", addr);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    int w;
    bus_access(addr, wdata, 4'hF, d, w);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
    int w;
    bus_access(addr, 32'h0, 4'h0, rdata, w);
  endtask

  task automatic rx_inject(input logic [7:0] b);
    @(negedge clk);
    uart_received = 1'b1;
    uart_rx_byte  = b;
    if (rx_exp.size() < 16) rx_exp.push_back(b);
    @(negedge clk);
    uart_received = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (tx_exp.size() == 0 && !uart_is_transmitting) break;
    end
    repeat (4) @(posedge clk);
    if (i >= 3000) begin
      checks++;
      errors++;
      $display("FAIL tx_drain_timeout: got %0d bytes pending, required 0", tx_exp.size());
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(32'h4, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s: got STATUS %h, required %h", name, d, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_ready, mem_rdata, irq, uart_transmit, uart_tx_byte} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h irq=%b tx=%b byte=%h, required all 0",
               mem_ready, mem_rdata, irq, uart_transmit, uart_tx_byte);
    end
    @(negedge clk);
    reset = 1'b0;
    check_status("reset_status", 32'h0000_0004);
    bus_read(32'h8, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h, required 0", d);
    end
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'hC, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reserved_read: got %h, required 0", d);
    end
    bus_read(32'h0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL empty_rx_read: got %h, required 0", d);
    end
  endtask

  task automatic test_tx_basic();
    int p0 = tx_pulses;
    for (int i = 0; i < 3; i++) begin
      tx_exp.push_back(8'h41 + 8'(i));
      bus_write(32'h0, 32'h41 + i);
    end
    wait_tx_drain();
    checks++;
    if (tx_pulses - p0 !== 3) begin
      errors++;
      $display("FAIL tx_basic_pulses: got %0d, required 3", tx_pulses - p0);
    end
    check_status("tx_basic_empty", 32'h0000_0004);
  endtask

  task automatic test_tx_stall();
    int p0 = tx_pulses;
    int n;
    bit early;
    @(negedge clk);
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_exp.push_back(8'h60 + 8'(i));
      bus_write(32'h0, 32'h60 + i);
    end
    check_status("tx_full_status", 32'h0000_0018);
    @(negedge clk);
    tx_exp.push_back(8'h70);
    mem_valid = 1'b1;
    mem_addr  = 32'h0;
    mem_wdata = 32'h70;
    mem_wstrb = 4'hF;
    early = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (mem_ready) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL tx_stall: got mem_ready=1 while TX full, required 0");
    end
    @(negedge clk);
    force_busy = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (mem_ready) break;
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL tx_stall_release: got ready after %0d edges, required 2", n);
    end
    wait_tx_drain();
    checks++;
    if (tx_pulses - p0 !== 17) begin
      errors++;
      $display("FAIL tx_stall_pulses: got %0d, required 17", tx_pulses - p0);
    end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    for (int i = 0; i < 16; i++) rx_inject(8'h10 + 8'(i));
    check_status("rx_full_status", 32'h0010_0007);
    rx_inject(8'hEE);
    check_status("rx_overrun_status", 32'h0010_0027);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e = rx_exp.pop_front();
      bus_read(32'h0, d);
      checks++;
      if (d !== {24'h0, e}) begin
        errors++;
        $display("FAIL rx_order[%0d]: got %h, required %h", i, d, e);
      end
    end
    bus_read(32'h0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rx_after_drain: got %h, required 0", d);
    end
    check_status("overrun_sticky", 32'h0000_0024);
    @(negedge clk);
    uart_recv_error = 1'b1;
    @(negedge clk);
    uart_recv_error = 1'b0;
    check_status("frame_err", 32'h0000_0064);
    bus_write(32'h8, 32'h10);
    check_status("clr_err", 32'h0000_0004);
  endtask

  task automatic test_rx_read_collide();
    logic [31:0] d;
    logic [7:0]  e;
    for (int i = 0; i < 16; i++) rx_inject(8'hA0 + 8'(i));
    @(negedge clk);
    mem_valid     = 1'b1;
    mem_addr      = 32'h0;
    mem_wstrb     = 4'h0;
    uart_received = 1'b1;
    uart_rx_byte  = 8'h99;
    @(posedge clk);
    #1;
    uart_received = 1'b0;
    e = rx_exp.pop_front();
    rx_exp.push_back(8'h99);
    checks++;
    if (mem_ready !== 1'b1 || mem_rdata !== {24'h0, e}) begin
      errors++;
      $display("FAIL collide_read: got ready=%b data=%h, required 1 and %h", mem_ready, mem_rdata, e);
    end
    mem_valid = 1'b0;
    check_status("collide_no_overrun", 32'h0010_0007);
    for (int i = 0; i < 16; i++) begin
      e = rx_exp.pop_front();
      bus_read(32'h0, d);
      checks++;
      if (d !== {24'h0, e}) begin
        errors++;
        $display("FAIL collide_order[%0d]: got %h, required %h", i, d, e);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(32'h8, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_idle: got %b, required 0", irq);
    end
    @(negedge clk);
    uart_received = 1'b1;
    uart_rx_byte  = 8'h55;
    @(posedge clk);
    #1;
    uart_received = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_lag: got %b at push edge, required 0", irq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: got %b, required 1", irq);
    end
    bus_read(32'h0, d);
    checks++;
    if (d !== 32'h55) begin
      errors++;
      $display("FAIL irq_data: got %h, required 00000055", d);
    end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_drop: got %b, required 0", irq);
    end
    bus_write(32'h8, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_tx_empty: got %b, required 1", irq);
    end
    bus_read(32'h8, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL ctrl_readback: got %h, required 00000002", d);
    end
    bus_write(32'h8, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_disabled: got %b, required 0", irq);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int p0 = tx_pulses;
    @(negedge clk);
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) bus_write(32'h0, 32'hB0 + i);
    bus_write(32'h8, 32'h4);
    check_status("tx_flush", 32'h0000_0014);
    rx_inject(8'hC1);
    rx_inject(8'hC2);
    bus_write(32'h8, 32'h8);
    rx_exp.delete();
    check_status("rx_flush", 32'h0000_0014);
    @(negedge clk);
    force_busy = 1'b0;
    repeat (20) @(posedge clk);
    checks++;
    if (tx_pulses !== p0) begin
      errors++;
      $display("FAIL flush_no_tx: got %0d pulses, required 0", tx_pulses - p0);
    end
    bus_read(32'h0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL flush_rx_read: got %h, required 0", d);
    end
  endtask

  task automatic test_reset_mid();
    int p_at;
    bit seen = 1'b0;
    @(negedge clk);
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_exp.push_back(8'hD0 + 8'(i));
      bus_write(32'h0, 32'hD0 + i);
    end
    @(negedge clk);
    force_busy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_transmit) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_start: got no uart_transmit, required a pulse");
    end
    // Start pulse -> WAIT_HI -> WAIT_LO while the model core is still busy.
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tx_exp.delete();
    p_at = tx_pulses;
    #1;
    checks++;
    if ({mem_ready, mem_rdata, irq, uart_transmit, uart_tx_byte} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ready=%b rdata=%h irq=%b tx=%b byte=%h, required all 0",
               mem_ready, mem_rdata, irq, uart_transmit, uart_tx_byte);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(posedge clk);
    checks++;
    if (tx_pulses !== p_at) begin
      errors++;
      $display("FAIL reset_mid_no_tx: got %0d extra pulses, required 0", tx_pulses - p_at);
    end
    check_status("reset_mid_status", 32'h0000_0004);
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_stall();
    test_rx_overrun();
    test_rx_read_collide();
    test_irq();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
